// File: rtl/fifo_wr_arbiter_if.sv
// Signal bundle between four write requesters, the arbiter and the FIFO write port.
// The arbiter side uses the master modport; the environment uses slave.
interface fifo_wr_arbiter_if;
  logic [3:0]  req;
  logic [3:0]  last;
  logic [31:0] din;
  logic        fifo_full;
  logic [3:0]  ack;
  logic        fifo_w_en;
  logic [7:0]  fifo_data;
  logic [1:0]  owner;
  logic        busy;
  logic        abort;
  logic [15:0] beat_cnt_total;

  modport master (
    input  req, last, din, fifo_full,
    output ack, fifo_w_en, fifo_data, owner, busy, abort, beat_cnt_total
  );

  modport slave (
    output req, last, din, fifo_full,
    input  ack, fifo_w_en, fifo_data, owner, busy, abort, beat_cnt_total
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that merges four 8-bit requesters into one FIFO write port.
// Grants are packet-based, with a burst limit and an idle-owner timeout.
module fifo_wr_arbiter #(
  parameter int MAX_BURST = 16,
  parameter int IDLE_TMO  = 8
) (
  input logic               wclk,
  input logic               wrst,
  fifo_wr_arbiter_if.master bus
);

  localparam int              BW         = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0]   BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [7:0]      STALL_LAST = 8'(IDLE_TMO - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state;
  logic [1:0]    owner;
  logic [1:0]    rr_ptr;
  logic [BW-1:0] burst_cnt;
  logic [7:0]    stall_cnt;
  logic          abort_q;
  logic [15:0]   beat_cnt;

  logic          owner_req;
  logic          xfer;
  logic          pkt_end;
  logic          timeout;
  logic          grant_valid;
  logic [1:0]    grant_idx;
  logic [1:0]    cand;

  // NOTE: every variable written here gets a default first, otherwise paths that
  // skip an assignment would infer a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_ptr;
    cand        = rr_ptr;
    // Walk from the farthest slot back to rr_ptr so the nearest requester wins.
    for (int k = 3; k >= 0; k--) begin
      cand = rr_ptr + 2'(k);
      if (bus.req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign owner_req = bus.req[owner];
  // Reset overrides any in-flight beat so nothing is written or acknowledged.
  assign xfer      = (state == BUSY) && owner_req && !bus.fifo_full && !wrst;
  assign pkt_end   = bus.last[owner] || (burst_cnt == BURST_LAST);
  assign timeout   = (state == BUSY) && !owner_req && !bus.fifo_full &&
                     (stall_cnt == STALL_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state     <= IDLE;
      owner     <= 2'd0;
      rr_ptr    <= 2'd0;
      burst_cnt <= '0;
      stall_cnt <= 8'd0;
      abort_q   <= 1'b0;
      beat_cnt  <= 16'd0;
    end else begin
      abort_q <= 1'b0;
      if (xfer) beat_cnt <= beat_cnt + 16'd1;

      if (state == IDLE) begin
        if (grant_valid) begin
          state     <= BUSY;
          owner     <= grant_idx;
          rr_ptr    <= grant_idx + 2'd1;
          burst_cnt <= '0;
          stall_cnt <= 8'd0;
        end
      end else begin
        if (xfer) begin
          burst_cnt <= burst_cnt + BW'(1);
          stall_cnt <= 8'd0;
          if (pkt_end) state <= IDLE;
        end else if (owner_req) begin
          // Blocked only by a full FIFO: the owner is still active.
          stall_cnt <= 8'd0;
        end else if (timeout) begin
          state   <= IDLE;
          abort_q <= 1'b1;
        end else if (!bus.fifo_full) begin
          stall_cnt <= stall_cnt + 8'd1;
        end
      end
    end
  end

  assign bus.ack            = xfer ? (4'b0001 << owner) : 4'b0000;
  assign bus.fifo_w_en      = xfer;
  assign bus.fifo_data      = xfer ? bus.din[{owner, 3'b000} +: 8] : 8'h00;
  assign bus.owner          = owner;
  assign bus.busy           = (state == BUSY);
  assign bus.abort          = abort_q;
  assign bus.beat_cnt_total = beat_cnt;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed corner
// sequences and randomized traffic against a cycle-level reference model.
module tb_fifo_wr_arbiter;

  localparam int MAX_BURST = 16;
  localparam int IDLE_TMO  = 8;

  logic wclk = 1'b0;
  logic wrst;

  fifo_wr_arbiter_if bus();

  fifo_wr_arbiter #(
    .MAX_BURST(MAX_BURST),
    .IDLE_TMO (IDLE_TMO)
  ) dut (
    .wclk(wclk),
    .wrst(wrst),
    .bus (bus)
  );

  always #5 wclk = ~wclk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: grant held or not, who holds it, where rotation resumes,
  // beats and stalled cycles so far in this grant, and the running beat count.
  bit          m_busy;
  bit          m_abort;
  int          m_owner;
  int          m_rr;
  int          m_beats;
  int          m_stalls;
  logic [15:0] m_total;

  bit          r_rst;
  logic [3:0]  r_req;
  logic [3:0]  r_last;
  logic [31:0] r_din;
  bit          r_full;

  typedef struct {
    bit          rst;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [31:0] din;
    bit          full;
    logic [3:0]  ack;
    bit          wen;
    logic [7:0]  data;
    bit          busy;
    logic [1:0]  owner;
    bit          abort;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy   = 1'b0;
    m_abort  = 1'b0;
    m_owner  = 0;
    m_rr     = 0;
    m_beats  = 0;
    m_stalls = 0;
    m_total  = 16'd0;
  endtask

  function automatic bit m_xfer();
    return !r_rst && m_busy && r_req[m_owner] && !r_full;
  endfunction

  function automatic logic [63:0] model_vec();
    logic [3:0] a;
    logic [7:0] d;
    bit         x;
    a = 4'b0000;
    d = 8'h00;
    x = m_xfer();
    if (x) begin
      a[m_owner] = 1'b1;
      d          = r_din[8*m_owner +: 8];
    end
    return {31'b0, a, x, d, m_busy, m_abort, m_total, (m_busy ? 2'(m_owner) : 2'b00)};
  endfunction

  function automatic logic [63:0] dut_vec();
    return {31'b0, bus.ack, bus.fifo_w_en, bus.fifo_data, bus.busy, bus.abort,
            bus.beat_cnt_total, (bus.busy ? bus.owner : 2'b00)};
  endfunction

  task automatic model_step();
    bit x;
    x = m_xfer();
    if (r_rst) begin
      model_reset();
      return;
    end
    m_abort = 1'b0;
    if (x) m_total = m_total + 16'd1;
    if (!m_busy) begin
      for (int j = 0; j < 4; j++) begin
        if (r_req[(m_rr + j) % 4]) begin
          m_busy   = 1'b1;
          m_owner  = (m_rr + j) % 4;
          m_rr     = (m_owner + 1) % 4;
          m_beats  = 0;
          m_stalls = 0;
          break;
        end
      end
    end else if (x) begin
      m_beats++;
      m_stalls = 0;
      if (r_last[m_owner] || m_beats == MAX_BURST) m_busy = 1'b0;
    end else if (r_req[m_owner]) begin
      m_stalls = 0;
    end else if (!r_full) begin
      m_stalls++;
      if (m_stalls == IDLE_TMO) begin
        m_busy  = 1'b0;
        m_abort = 1'b1;
      end
    end
  endtask

  // Apply inputs, then compare against the model on the falling edge.
  task automatic drive(input bit rst, input logic [3:0] req, input logic [3:0] last,
                       input logic [31:0] din, input bit full);
    r_rst = rst; r_req = req; r_last = last; r_din = din; r_full = full;
    wrst          = rst;
    bus.req       = req;
    bus.last      = last;
    bus.din       = din;
    bus.fifo_full = full;
    @(negedge wclk);
    check("model", dut_vec(), model_vec());
  endtask

  task automatic finish_cycle();
    model_step();
    @(posedge wclk);
    #1;
  endtask

  task automatic cycle(input bit rst, input logic [3:0] req, input logic [3:0] last,
                       input logic [31:0] din, input bit full);
    drive(rst, req, last, din, full);
    finish_cycle();
  endtask

  task automatic hard_reset();
    r_rst = 1'b1; r_req = 4'b0; r_last = 4'b0; r_din = 32'h0; r_full = 1'b0;
    wrst          = 1'b1;
    bus.req       = 4'b0;
    bus.last      = 4'b0;
    bus.din       = 32'h0;
    bus.fifo_full = 1'b0;
    @(posedge wclk);
    #1;
    model_reset();
  endtask

  initial begin
    int          grants[$];
    int          exp_order[5];
    bit          prev_busy;
    int          wen_cnt;
    int          abort_cnt;
    int          dens;
    logic [3:0]  rq;

    exp_order = '{0, 1, 2, 3, 0};

    //           rst req      last     din           full  ack      wen data   busy own  abort
    tbl[0] = '{1'b1, 4'b0000, 4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    tbl[1] = '{1'b0, 4'b0100, 4'b0000, 32'hA1B2C3D4, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    tbl[2] = '{1'b0, 4'b0100, 4'b0000, 32'h00110000, 1'b0, 4'b0100, 1'b1, 8'h11, 1'b1, 2'd2, 1'b0};
    tbl[3] = '{1'b0, 4'b0100, 4'b0000, 32'h00220000, 1'b0, 4'b0100, 1'b1, 8'h22, 1'b1, 2'd2, 1'b0};
    tbl[4] = '{1'b0, 4'b0100, 4'b0100, 32'h00330000, 1'b0, 4'b0100, 1'b1, 8'h33, 1'b1, 2'd2, 1'b0};
    tbl[5] = '{1'b0, 4'b0000, 4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    tbl[6] = '{1'b0, 4'b0001, 4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    tbl[7] = '{1'b0, 4'b0001, 4'b0000, 32'h000000AA, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0};
    tbl[8] = '{1'b0, 4'b0001, 4'b0001, 32'h000000BB, 1'b0, 4'b0001, 1'b1, 8'hBB, 1'b1, 2'd0, 1'b0};
    tbl[9] = '{1'b0, 4'b0000, 4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};

    // Vector table: reset state, a 3-beat packet from requester 2, a full stall.
    hard_reset();
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].last, tbl[i].din, tbl[i].full);
      check($sformatf("vec%0d", i),
            {bus.ack, bus.fifo_w_en, bus.fifo_data, bus.busy,
             (bus.busy ? bus.owner : 2'b00), bus.abort},
            {tbl[i].ack, tbl[i].wen, tbl[i].data, tbl[i].busy, tbl[i].owner, tbl[i].abort});
      finish_cycle();
    end

    // All four requesting, no packet ends: 16-beat grants rotating 0,1,2,3,0.
    hard_reset();
    prev_busy = 1'b0;
    for (int c = 0; c < 85; c++) begin
      drive(1'b0, 4'b1111, 4'b0000, $urandom, 1'b0);
      if (bus.busy === 1'b1 && !prev_busy) grants.push_back(int'(bus.owner));
      prev_busy = (bus.busy === 1'b1);
      if (c > 0 && c % 17 == 0) check($sformatf("rot_gap%0d", c), bus.busy, 1'b0);
      if (c == 68) check("rot_total64", bus.beat_cnt_total, 16'd64);
      finish_cycle();
    end
    check("rot_grants", grants.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("rot_owner%0d", i), (i < grants.size()) ? grants[i] : 99, exp_order[i]);

    // Owner 1 mid-packet, FIFO full for 20 cycles, then resumes immediately.
    hard_reset();
    cycle(1'b0, 4'b0010, 4'b0000, 32'h0, 1'b0);
    cycle(1'b0, 4'b0010, 4'b0000, 32'h00004100, 1'b0);
    cycle(1'b0, 4'b0010, 4'b0000, 32'h00004200, 1'b0);
    wen_cnt   = 0;
    abort_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, 4'b0010, 4'b0000, 32'h00004300, 1'b1);
      if (bus.fifo_w_en !== 1'b0) wen_cnt++;
      if (bus.abort !== 1'b0) abort_cnt++;
      finish_cycle();
    end
    check("full_no_wen", wen_cnt, 0);
    check("full_no_abort", abort_cnt, 0);
    drive(1'b0, 4'b0010, 4'b0000, 32'h00004400, 1'b0);
    check("full_resume", {bus.busy, bus.fifo_w_en, bus.ack, bus.fifo_data},
          {1'b1, 1'b1, 4'b0010, 8'h44});
    finish_cycle();

    // Owner 0 goes silent for IDLE_TMO cycles while requester 3 waits.
    hard_reset();
    cycle(1'b0, 4'b0001, 4'b0000, 32'h0, 1'b0);
    cycle(1'b0, 4'b0001, 4'b0000, 32'h0, 1'b0);
    cycle(1'b0, 4'b0001, 4'b0000, 32'h0, 1'b0);
    abort_cnt = 0;
    for (int c = 0; c < IDLE_TMO; c++) begin
      drive(1'b0, 4'b1000, 4'b0000, 32'h0, 1'b0);
      if (bus.abort !== 1'b0) abort_cnt++;
      finish_cycle();
    end
    check("tmo_no_early_abort", abort_cnt, 0);
    drive(1'b0, 4'b1000, 4'b0000, 32'h0, 1'b0);
    check("tmo_abort", {bus.abort, bus.busy, bus.fifo_w_en}, {1'b1, 1'b0, 1'b0});
    finish_cycle();
    drive(1'b0, 4'b1000, 4'b0000, 32'h0, 1'b0);
    check("tmo_regrant", {bus.abort, bus.busy, bus.owner}, {1'b0, 1'b1, 2'd3});
    finish_cycle();

    // Reset during beat 5 of a burst, then requesters 1 and 2 compete.
    hard_reset();
    for (int c = 0; c < 5; c++) cycle(1'b0, 4'b1111, 4'b0000, $urandom, 1'b0);
    drive(1'b1, 4'b1111, 4'b0000, 32'hFFFFFFFF, 1'b0);
    check("rst_gate", {bus.ack, bus.fifo_w_en}, {4'b0000, 1'b0});
    finish_cycle();
    drive(1'b0, 4'b0110, 4'b0000, 32'h0, 1'b0);
    check("rst_clear", {bus.ack, bus.fifo_w_en, bus.busy, bus.abort, bus.owner,
                        bus.beat_cnt_total}, {4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0});
    finish_cycle();
    drive(1'b0, 4'b0110, 4'b0000, 32'h0, 1'b0);
    check("rst_first_grant", {bus.busy, bus.owner}, {1'b1, 2'd1});
    finish_cycle();

    // Randomized traffic with varying request density, packet ends, full and resets.
    hard_reset();
    for (int c = 0; c < 3000; c++) begin
      case ((c / 200) % 3)
        0:       dens = 90;
        1:       dens = 50;
        default: dens = 15;
      endcase
      for (int b = 0; b < 4; b++) rq[b] = ($urandom_range(0, 99) < dens);
      cycle(($urandom_range(0, 499) == 0), rq,
            ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
            $urandom, ($urandom_range(0, 7) == 0));
    end

    // Beat counter wrap: 65540 beats in 16-beat bursts.
    hard_reset();
    for (int c = 0; c < 4096 * 17 + 5; c++) cycle(1'b0, 4'b1111, 4'b0000, $urandom, 1'b0);
    check("wrap_total", bus.beat_cnt_total, 16'd4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
